// File: rtl/hd6309_bus_responder.sv
// HD6309 external bus target: synchronizes E/Q, turns CPU cycles into a req/ack
// fabric transaction, stretches the CPU with mrdy and posts writes in the background.
module hd6309_bus_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = 64,
    parameter int TW           = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e,
    input  logic        q,
    input  logic        ba,
    input  logic        rw,
    input  logic [15:0] addr_out,
    input  logic [7:0]  data_out,
    output logic [7:0]  data_in,
    output logic        mrdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, PEND, HOLD} state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] e_sync, q_sync;
    logic                   es, qs, es_d, qs_d;
    logic                   q_rise, q_fall, e_fall;
    logic [TW-1:0]          tmo_cnt;
    logic                   done, expire;

    assign es     = e_sync[SYNC_STAGES-1];
    assign qs     = q_sync[SYNC_STAGES-1];
    assign q_rise = qs & ~qs_d;
    assign q_fall = ~qs & qs_d;
    assign e_fall = ~es & es_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_sync <= '0;
            q_sync <= '0;
            es_d   <= 1'b0;
            qs_d   <= 1'b0;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], e};
            q_sync <= {q_sync[SYNC_STAGES-2:0], q};
            es_d   <= es;
            qs_d   <= qs;
        end
    end

    // Ack beats expiry when both land in the same clk.
    assign done   = mem_req & mem_ack;
    assign expire = mem_req & ~mem_ack & (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_in     <= 8'hFF;
            mrdy        <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            if (mem_req && tmo_cnt != TMO_LAST)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (done || expire)
                mem_req <= 1'b0;
            if (expire)
                timeout_err <= 1'b1;

            case (state)
                IDLE: if (q_rise && !es) state <= ADDR;
                ADDR: begin
                    // A posted write still owns the fabric; hold the CPU until it retires.
                    if (mem_req) begin
                        mrdy <= 1'b0;
                    end else begin
                        mem_addr <= addr_out;
                        if (ba) begin
                            mrdy  <= 1'b1;
                            state <= IDLE;
                        end else if (rw) begin
                            mem_we  <= 1'b0;
                            mem_req <= 1'b1;
                            tmo_cnt <= '0;
                            mrdy    <= 1'b0;
                            state   <= PEND;
                        end else begin
                            mrdy  <= 1'b1;
                            state <= WDATA;
                        end
                    end
                end
                WDATA: if (q_fall && es) begin
                    mem_wdata <= data_out;
                    mem_we    <= 1'b1;
                    mem_req   <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= IDLE;
                end
                PEND: begin
                    if (done) begin
                        data_in <= mem_rdata;
                        mrdy    <= 1'b1;
                        state   <= HOLD;
                    end else if (expire) begin
                        data_in <= 8'hFF;
                        mrdy    <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: if (e_fall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hd6309_bus_responder.md
Name: hd6309_bus_responder

Overview:
- FPGA-side target for the external HD6309 bus.
- Turns asynchronous E/Q-timed CPU cycles into a synchronous req/ack memory transaction on clk.
- Returns read data on data_in and stretches CPU cycles via mrdy until memory completes.
- Sits between the GPIO CPU adapter and the SoC memory/peripheral fabric.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the e and q synchronizers (minimum 2).
- TIMEOUT_CLKS, 64: clk cycles a request may stay pending before it is abandoned.
- TW, 7: timeout counter width; must hold TIMEOUT_CLKS.

Ports:
- clk  in  1  system clock; must be at least 8x the E frequency.
- rst_n  in  1  asynchronous active-low reset.
- e  in  1  CPU E clock, asynchronous.
- q  in  1  CPU Q clock, asynchronous.
- ba  in  1  bus available; 1 means the CPU has released the bus.
- rw  in  1  1 = read, 0 = write.
- addr_out  in  16  CPU address.
- data_out  in  8  CPU write data.
- data_in  out  8  read data returned to the CPU.
- mrdy  out  1  memory ready; 0 stretches the CPU cycle.
- mem_req  out  1  transaction request to the fabric.
- mem_we  out  1  1 = write transaction.
- mem_addr  out  16  transaction address.
- mem_wdata  out  8  transaction write data.
- mem_ack  in  1  single-clk completion pulse from the fabric.
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- timeout_err  out  1  sticky flag: a transaction timed out.

Behaviour:
- Reset values: data_in=8'hFF, mrdy=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0, FSM=IDLE, timeout counter=0.
- Asynchronous reset mid-transaction drops mem_req at once. The fabric must tolerate an abandoned request.
- Clock-domain crossing:
  - e and q pass through SYNC_STAGES flops each; es/qs denote the synchronized values.
  - Edges are detected on es/qs.
  - addr_out, rw, ba and data_out are sampled directly at detected edges; the CPU holds them stable across those edges.
- IDLE -> ADDR: on the qs rising edge while es=0.
- ADDR (1 clk):
  - Latch mem_addr<=addr_out and latch rw.
  - ba=1: dead cycle, no request, return to IDLE.
  - Read: mem_we<=0, mem_req<=1, mrdy<=0, go to PEND.
  - Write: go to WDATA.
  - If a posted write is still pending on entry, mrdy<=0 and ADDR stalls until that write's ack. The new cycle is then processed normally.
- WDATA: on the qs falling edge while es=1:
  - mem_wdata<=data_out, mem_we<=1, mem_req<=1.
  - Return to IDLE (posted write); mrdy stays 1.
  - The write's ack/timeout is handled in the background by the same counter.
- PEND: mem_req, mem_we, mem_addr, mem_wdata held stable.
  - mem_ack=1: mem_req<=0; data_in<=mem_rdata; mrdy<=1 next clk; go to HOLD.
  - Timeout counter reaches TIMEOUT_CLKS-1 without ack: mem_req<=0, data_in<=8'hFF, mrdy<=1, timeout_err<=1, go to HOLD.
  - Ack arriving in the same clk as expiry: ack wins, no error.
- HOLD: data_in held; on the es falling edge go to IDLE. data_in keeps its value until the next read completes.
- Timeout counter: clears whenever mem_req rises, counts each clk while mem_req=1, saturates.
- mem_ack while mem_req=0 is ignored.
- At most one outstanding transaction: mem_req is never reasserted in the clk it drops.
- timeout_err clears only on reset.
- Read latency: mrdy low from 2 clks after the qs edge until 1 clk after mem_ack.

Test Plan:
- Read, zero-wait fabric: addr 16'h1234, rw=1, ack 1 clk after req with rdata 8'h5A -> one mem_req pulse with addr 1234, we=0; data_in=5A before E falls; mrdy low for 1-2 clks.
- Slow read: ack 40 clks after req -> mrdy held 0 for the whole wait, req stable, data_in updates only after ack.
- Posted write then read: write 8'hC3 to 16'h8000, ack delayed 30 clks, read of 16'h8001 immediately after -> write seen with wdata C3; read ADDR stalls with mrdy=0 until write ack, then read issued.
- Timeout: never ack a read -> req drops after 64 clks, data_in=FF, mrdy=1, timeout_err=1 and stays 1 across following good cycles.
- Dead cycle and boundary: ba=1 cycle -> no mem_req. Ack on exactly clk 63 -> no timeout_err. Spurious mem_ack in IDLE -> no state change.
- Reset mid-PEND: rst_n low while mrdy=0 -> mem_req=0, mrdy=1, data_in=FF immediately; normal read succeeds after release.
